// File: rtl/ball_ctrl.sv
// Game sequencing for the ball block: serve timing, bounce/miss detection, scoring.
// Drives the ball's direction, pause and re-centre inputs. Every output is registered.
module ball_ctrl #(
  parameter int H_MIN      = 10,
  parameter int H_MAX      = 630,
  parameter int V_MIN      = 10,
  parameter int V_MAX      = 470,
  parameter int BALL_SIZE  = 8,
  parameter int PAD_LX     = 20,
  parameter int PAD_RX     = 620,
  parameter int PAD_LEN    = 64,
  parameter int WIN_SCORE  = 7,
  parameter int SERVE_WAIT = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [10:0] h_pos_i,
  input  logic [10:0] v_pos_i,
  input  logic [10:0] padl_v_i,
  input  logic [10:0] padr_v_i,
  output logic        dh_o,
  output logic        dv_o,
  output logic        pause_o,
  output logic        ball_rst_o,
  output logic [3:0]  score_l_o,
  output logic [3:0]  score_r_o,
  output logic [1:0]  state_o,
  output logic        winner_o
);

  localparam int CW = (SERVE_WAIT > 1) ? $clog2(SERVE_WAIT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SERVE, S_PLAY, S_POINT, S_OVER} state_t;

  state_t         state_q;
  logic [1:0]     state_out_q;
  logic [CW-1:0]  cnt_q;
  logic           dh_q, dv_q, pause_q, ball_rst_q, winner_q, last_right_q;
  logic [3:0]     score_l_q, score_r_q;

  // Sums are 12 bits so the far edge of the ball never wraps; bit 10 set means underflow past 0.
  logic [11:0] h_ext, v_ext, h_far, v_far, padl_ext, padr_ext;
  logic        left_miss, right_miss, hit_l, hit_r, hit_top, hit_bot, ovl_l, ovl_r;
  logic [3:0]  scorer_score;

  assign h_ext    = {1'b0, h_pos_i};
  assign v_ext    = {1'b0, v_pos_i};
  assign h_far    = h_ext + 12'(BALL_SIZE);
  assign v_far    = v_ext + 12'(BALL_SIZE);
  assign padl_ext = {1'b0, padl_v_i};
  assign padr_ext = {1'b0, padr_v_i};

  assign ovl_l = (v_far > padl_ext) && (v_ext < padl_ext + 12'(PAD_LEN));
  assign ovl_r = (v_far > padr_ext) && (v_ext < padr_ext + 12'(PAD_LEN));

  assign left_miss  = !dh_q && ((h_ext <= 12'(H_MIN)) || h_pos_i[10]);
  assign right_miss = dh_q && (h_far >= 12'(H_MAX));
  assign hit_l      = !dh_q && (h_ext > 12'(PAD_LX - 4)) && (h_ext <= 12'(PAD_LX)) && ovl_l;
  assign hit_r      = dh_q && (h_far >= 12'(PAD_RX)) && (h_far < 12'(PAD_RX + 4)) && ovl_r;
  assign hit_top    = !dv_q && ((v_ext <= 12'(V_MIN)) || v_pos_i[10]);
  assign hit_bot    = dv_q && (v_far >= 12'(V_MAX));

  assign scorer_score = last_right_q ? score_r_q : score_l_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      state_out_q  <= 2'd0;
      cnt_q        <= '0;
      dh_q         <= 1'b1;
      dv_q         <= 1'b0;
      pause_q      <= 1'b1;
      ball_rst_q   <= 1'b0;
      winner_q     <= 1'b0;
      last_right_q <= 1'b0;
      score_l_q    <= 4'd0;
      score_r_q    <= 4'd0;
    end else begin
      ball_rst_q <= 1'b0;
      case (state_q)
        S_IDLE, S_OVER: begin
          if (start_i) begin
            state_q     <= S_SERVE;
            state_out_q <= 2'd1;
            cnt_q       <= '0;
            dh_q        <= 1'b1;
            dv_q        <= 1'b0;
            ball_rst_q  <= 1'b1;
            winner_q    <= 1'b0;
            score_l_q   <= 4'd0;
            score_r_q   <= 4'd0;
          end
        end
        S_SERVE: begin
          if (cnt_q == CW'(SERVE_WAIT - 1)) begin
            state_q     <= S_PLAY;
            state_out_q <= 2'd2;
            cnt_q       <= '0;
            pause_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_PLAY: begin
          // A miss takes priority over, and suppresses, any bounce this cycle.
          if (left_miss) begin
            score_r_q    <= score_r_q + 4'd1;
            last_right_q <= 1'b1;
            pause_q      <= 1'b1;
            state_q      <= S_POINT;
          end else if (right_miss) begin
            score_l_q    <= score_l_q + 4'd1;
            last_right_q <= 1'b0;
            pause_q      <= 1'b1;
            state_q      <= S_POINT;
          end else begin
            if (hit_l) dh_q <= 1'b1;
            else if (hit_r) dh_q <= 1'b0;
            if (hit_top) dv_q <= 1'b1;
            else if (hit_bot) dv_q <= 1'b0;
          end
        end
        S_POINT: begin
          if (scorer_score == 4'(WIN_SCORE)) begin
            state_q     <= S_OVER;
            state_out_q <= 2'd3;
            winner_q    <= last_right_q;
          end else begin
            state_q     <= S_SERVE;
            state_out_q <= 2'd1;
            cnt_q       <= '0;
            ball_rst_q  <= 1'b1;
            dh_q        <= ~last_right_q;
            dv_q        <= ~dv_q;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          state_out_q <= 2'd0;
          pause_q     <= 1'b1;
        end
      endcase
    end
  end

  assign dh_o       = dh_q;
  assign dv_o       = dv_q;
  assign pause_o    = pause_q;
  assign ball_rst_o = ball_rst_q;
  assign score_l_o  = score_l_q;
  assign score_r_o  = score_r_q;
  assign state_o    = state_out_q;
  assign winner_o   = winner_q;

endmodule
